// File: rtl/rgb_to_ycbcr_pipe.sv
// Fully pipelined BT.601 full-range RGB -> YCbCr converter with valid/ready flow control.
// Input capture, multiply, sum+round and offset+clip stages all advance together; an output stall freezes every stage.
module rgb_to_ycbcr_pipe #(
   parameter int WIDTH  = 8,
   parameter int USER_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  red_ch,
   input  logic [WIDTH-1:0]  green_ch,
   input  logic [WIDTH-1:0]  blue_ch,
   input  logic [USER_W-1:0] in_user,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  luma_ch,
   output logic [WIDTH-1:0]  cb_ch,
   output logic [WIDTH-1:0]  cr_ch,
   output logic [USER_W-1:0] out_user
);

   localparam int PW = WIDTH + 9;
   localparam int SW = WIDTH + 11;

   localparam logic signed [PW-1:0] C_YR  = PW'(77);
   localparam logic signed [PW-1:0] C_YG  = PW'(150);
   localparam logic signed [PW-1:0] C_YB  = PW'(29);
   localparam logic signed [PW-1:0] C_CBR = PW'(-43);
   localparam logic signed [PW-1:0] C_CBG = PW'(-85);
   localparam logic signed [PW-1:0] C_CBB = PW'(128);
   localparam logic signed [PW-1:0] C_CRR = PW'(128);
   localparam logic signed [PW-1:0] C_CRG = PW'(-107);
   localparam logic signed [PW-1:0] C_CRB = PW'(-21);

   localparam logic signed [SW-1:0] HALF  = SW'(1 << (WIDTH-1));
   localparam logic signed [SW-1:0] MAXV  = SW'((1 << WIDTH) - 1);
   localparam logic signed [SW-1:0] RND   = SW'(128);

   function automatic logic signed [PW-1:0] mul(input logic [WIDTH-1:0] chan,
                                                 input logic signed [PW-1:0] coef);
      logic signed [PW-1:0] ext;
      ext = signed'({9'b0, chan});
      return ext * coef;
   endfunction

   function automatic logic signed [SW-1:0] round_sum(input logic signed [PW-1:0] a,
                                                       input logic signed [PW-1:0] b,
                                                       input logic signed [PW-1:0] c);
      logic signed [SW-1:0] s;
      s = SW'(a) + SW'(b) + SW'(c) + RND;
      return s >>> 8;
   endfunction

   function automatic logic [WIDTH-1:0] clip(input logic signed [SW-1:0] v);
      logic [WIDTH-1:0] r;
      if (v < 0)
         r = '0;
      else if (v > MAXV)
         r = '1;
      else
         r = v[WIDTH-1:0];
      return r;
   endfunction

   logic stall;
   logic vld_p0, vld_p1, vld_p2, vld_p3;

   logic [WIDTH-1:0]  r_p0, g_p0, b_p0;
   logic [USER_W-1:0] user_p0, user_p1, user_p2;

   logic signed [PW-1:0] yr_p1, yg_p1, yb_p1;
   logic signed [PW-1:0] cbr_p1, cbg_p1, cbb_p1;
   logic signed [PW-1:0] crr_p1, crg_p1, crb_p1;

   logic signed [SW-1:0] y_p2, cb_p2, cr_p2;

   assign stall     = vld_p3 && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = vld_p3;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
      end else if (!stall) begin
         vld_p0 <= in_valid;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
         vld_p3 <= vld_p2;
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) begin
         // p0: capture the pixel and its sideband
         r_p0    <= red_ch;
         g_p0    <= green_ch;
         b_p0    <= blue_ch;
         user_p0 <= in_user;
         // p1: nine coefficient products
         yr_p1   <= mul(r_p0, C_YR);
         yg_p1   <= mul(g_p0, C_YG);
         yb_p1   <= mul(b_p0, C_YB);
         cbr_p1  <= mul(r_p0, C_CBR);
         cbg_p1  <= mul(g_p0, C_CBG);
         cbb_p1  <= mul(b_p0, C_CBB);
         crr_p1  <= mul(r_p0, C_CRR);
         crg_p1  <= mul(g_p0, C_CRG);
         crb_p1  <= mul(b_p0, C_CRB);
         user_p1 <= user_p0;
         // p2: sum, round and floor-shift back to channel scale
         y_p2    <= round_sum(yr_p1, yg_p1, yb_p1);
         cb_p2   <= round_sum(cbr_p1, cbg_p1, cbb_p1);
         cr_p2   <= round_sum(crr_p1, crg_p1, crb_p1);
         user_p2 <= user_p1;
      end
   end

   // p3: chroma offset, clip to the code range, present on the outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         luma_ch  <= '0;
         cb_ch    <= '0;
         cr_ch    <= '0;
         out_user <= '0;
      end else if (!stall) begin
         luma_ch  <= clip(y_p2);
         cb_ch    <= clip(cb_p2 + HALF);
         cr_ch    <= clip(cr_p2 + HALF);
         out_user <= user_p2;
      end
   end

endmodule

// File: tb/tb_rgb_to_ycbcr_pipe.sv
// Bench for rgb_to_ycbcr_pipe (WIDTH=8): directed corner pixels, grey sweep, random stalled stream,
// full-rate streaming and mid-stream reset, all scored against an integer reference model.
module tb_rgb_to_ycbcr_pipe;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] red_ch = '0, green_ch = '0, blue_ch = '0;
   logic [1:0] in_user = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] luma_ch, cb_ch, cr_ch;
   logic [1:0] out_user;

   rgb_to_ycbcr_pipe #(.WIDTH(8), .USER_W(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .red_ch(red_ch), .green_ch(green_ch), .blue_ch(blue_ch), .in_user(in_user),
      .out_valid(out_valid), .out_ready(out_ready),
      .luma_ch(luma_ch), .cb_ch(cb_ch), .cr_ch(cr_ch), .out_user(out_user)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  y;
      logic [7:0]  cb;
      logic [7:0]  cr;
      logic [1:0]  u;
      logic [31:0] acc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        lat_chk = 1'b0;
   logic        prev_stall = 1'b0;
   logic [25:0] prev_out = '0;
   logic        last_ov = 1'b0;
   logic        a;

   function automatic logic [7:0] clip8(input int v);
      logic [7:0] r;
      if (v < 0) r = 8'd0;
      else if (v > 255) r = 8'd255;
      else r = v[7:0];
      return r;
   endfunction

   // Plain integer BT.601 full-range reference; >>> on int is a floor divide by 256.
   function automatic logic [23:0] model(input int r, input int g, input int b);
      int y, cb, cr;
      y  = (77*r + 150*g + 29*b + 128) >>> 8;
      cb = ((-43*r - 85*g + 128*b + 128) >>> 8) + 128;
      cr = ((128*r - 107*g - 21*b + 128) >>> 8) + 128;
      return {clip8(y), clip8(cb), clip8(cr)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rs, input logic v, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic [1:0] u, input logic ordy,
                       input logic [23:0] e, output logic acc);
      exp_t x;
      @(negedge clk);
      rst = rs; in_valid = v; red_ch = r; green_ch = g; blue_ch = b; in_user = u; out_ready = ordy;
      #1;
      acc = 1'b0;
      if (rs) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", 32'({luma_ch, cb_ch, cr_ch, out_user}), 32'(prev_out));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               x = q.pop_front();
               chk("luma", 32'(luma_ch), 32'(x.y));
               chk("cb", 32'(cb_ch), 32'(x.cb));
               chk("cr", 32'(cr_ch), 32'(x.cr));
               chk("user", 32'(out_user), 32'(x.u));
               if (lat_chk) chk("latency", 32'(cyc - 1) - x.acc, 32'd3);
            end
         end
         if (in_valid && in_ready) begin
            q.push_back('{e[23:16], e[15:8], e[7:0], u, 32'(cyc)});
            acc = 1'b1;
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {luma_ch, cb_ch, cr_ch, out_user};
      end
      last_ov = out_valid;
      cyc++;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 40) begin
         step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b1, 24'd0, a);
         n++;
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      logic [7:0] rr, gg, bb;
      int idx, guard;

      // Reset state
      step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b1, 24'd0, a);
      step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b1, 24'd0, a);
      step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b1, 24'd0, a);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_outputs", 32'({luma_ch, cb_ch, cr_ch, out_user}), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed corner pixels with hand-derived expectations, latency checked
      lat_chk = 1'b1;
      step(1'b0, 1'b1, 8'd0,   8'd0,   8'd0,   2'd1, 1'b1, {8'd0,   8'd128, 8'd128}, a);
      step(1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 2'd2, 1'b1, {8'd255, 8'd128, 8'd128}, a);
      step(1'b0, 1'b1, 8'd255, 8'd0,   8'd0,   2'd3, 1'b1, {8'd77,  8'd85,  8'd255}, a);
      step(1'b0, 1'b1, 8'd0,   8'd0,   8'd255, 2'd0, 1'b1, {8'd29,  8'd255, 8'd107}, a);
      step(1'b0, 1'b1, 8'd0,   8'd255, 8'd0,   2'd1, 1'b1, {8'd149, 8'd43,  8'd21},  a);
      drain();

      // Grey sweep: Y follows the level, chroma sits exactly at mid-code
      for (int g = 0; g < 256; g++)
         step(1'b0, 1'b1, 8'(g), 8'(g), 8'(g), 2'(g), 1'b1, {8'(g), 8'd128, 8'd128}, a);
      drain();

      // Random stream with random backpressure
      lat_chk = 1'b0;
      idx = 0; guard = 0;
      rr = 8'($urandom); gg = 8'($urandom); bb = 8'($urandom);
      while (idx < 100 && guard < 3000) begin
         step(1'b0, 1'($urandom_range(0, 3) != 0), rr, gg, bb, 2'(idx), 1'($urandom_range(0, 1)),
              model(rr, gg, bb), a);
         if (a) begin
            idx++;
            rr = 8'($urandom); gg = 8'($urandom); bb = 8'($urandom);
         end
         guard++;
      end
      chk("rand_accepted", 32'(idx), 32'd100);
      drain();

      // Full-rate streaming: one output per clock once filled
      lat_chk = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rr = 8'($urandom); gg = 8'($urandom); bb = 8'($urandom);
         step(1'b0, 1'b1, rr, gg, bb, 2'(i), 1'b1, model(rr, gg, bb), a);
         chk("stream_accept", 32'(a), 32'd1);
         if (i >= 4) chk("stream_valid", 32'(last_ov), 32'd1);
      end
      drain();

      // Reset with three pixels in flight and downstream not ready
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 8'd200, 8'd10, 8'd90, 2'(i), 1'b0, model(200, 10, 90), a);
      step(1'b1, 1'b1, 8'd1, 8'd2, 8'd3, 2'd0, 1'b0, 24'd0, a);
      step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 24'd0, a);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_outputs", 32'({luma_ch, cb_ch, cr_ch, out_user}), 32'd0);
      chk("midrst_queue", 32'(q.size()), 32'd0);
      step(1'b0, 1'b1, 8'd100, 8'd150, 8'd50, 2'd2, 1'b1, model(100, 150, 50), a);
      chk("midrst_accept", 32'(a), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b1, 24'd0, a);
         chk("midrst_no_early", 32'(last_ov), 32'd0);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
